// File: rtl/param_regfile.sv
// param_regfile: parametrised multi-port register file with optional bypass and hardwired-zero R0
module dff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk) begin
        if (rst) q <= '0;
        else q <= en ? d : q;
    end
endmodule

module param_regfile #(
    parameter int WIDTH    = 16,
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 3,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_R0  = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*WIDTH-1:0]  rd_data,
    output logic                     err
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] NR = (ADDR_W + 1)'(NUM_REGS);
    logic [WIDTH-1:0] regs [DEPTH];
    logic in_range, writable, err_d;
    assign in_range = {1'b0, wr_addr} < NR;
    assign writable = wr_en && !rst && in_range && !(ZERO_R0 != 0 && wr_addr == '0);
    assign err_d    = wr_en && !rst && !in_range;
    dff #(.W(1)) u_err (.clk(clk), .rst(rst), .en(1'b1), .d(err_d), .q(err));
    // Unimplemented and hardwired-zero slots read as constant 0, so reads need no range check
    for (genvar r = 0; r < DEPTH; r++) begin : g_reg
        if (r < NUM_REGS && !(ZERO_R0 != 0 && r == 0)) begin : g_ff
            dff #(.W(WIDTH)) u_ff (
                .clk(clk),
                .rst(rst),
                .en(writable && wr_addr == ADDR_W'(r)),
                .d(wr_data),
                .q(regs[r])
            );
        end else begin : g_zero
            assign regs[r] = '0;
        end
    end
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        assign ra = rd_addr[i*ADDR_W +: ADDR_W];
        assign rd_data[i*WIDTH +: WIDTH] = (BYPASS != 0 && writable && ra == wr_addr) ? wr_data : regs[ra];
    end
endmodule

// File: tb/tb_param_regfile.sv
// tb_param_regfile: directed checks across default, no-bypass, zero-R0 and 6-entry configurations
module tb_param_regfile;
    logic clk = 0;
    logic rst, wr_en;
    logic [2:0] wr_addr;
    logic [15:0] wr_data;
    logic [5:0] rd_addr;
    logic [31:0] rd0, rd1, rd2, rd3;
    logic err0, err1, err2, err3;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    param_regfile u_d0 (.clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
                        .rd_addr(rd_addr), .rd_data(rd0), .err(err0));
    param_regfile #(.BYPASS(0)) u_d1 (.clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
                        .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd1), .err(err1));
    param_regfile #(.ZERO_R0(1)) u_d2 (.clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
                        .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd2), .err(err2));
    param_regfile #(.NUM_REGS(6)) u_d3 (.clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
                        .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd3), .err(err3));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        wr_en = 1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 0;
    endtask

    initial begin
        rst = 1; wr_en = 0; wr_addr = 0; wr_data = 0; rd_addr = 0;
        tick(); tick();
        rst = 0;
        rd_addr = {3'd5, 3'd3};
        #1;
        chk("reset_rd", rd0, 32'h0);
        chk("reset_err", {31'b0, err0}, 32'h0);

        wr(3'd3, 16'hBEEF);
        #1;
        chk("r3_beef", rd0[15:0], 32'hBEEF);
        rst = 1;
        #1;
        chk("r3_in_reset_cycle", rd0[15:0], 32'hBEEF);
        tick();
        rst = 0;
        #1;
        chk("r3_after_reset_d0", rd0[15:0], 32'h0);
        chk("r3_after_reset_d1", rd1[15:0], 32'h0);
        chk("err_after_reset", {31'b0, err0}, 32'h0);

        wr(3'd5, 16'h1234);
        rd_addr = {3'd5, 3'd5};
        #1;
        chk("r5_both_ports", rd0, 32'h1234_1234);
        rd_addr = {3'd7, 3'd0};
        #1;
        chk("others_zero", rd0, 32'h0);

        wr(3'd2, 16'h00AA);
        wr_en = 1; wr_addr = 3'd2; wr_data = 16'h5555; rd_addr = {3'd5, 3'd2};
        #1;
        chk("bypass_on", rd0, 32'h1234_5555);
        chk("bypass_off_old", rd1[15:0], 32'h00AA);
        tick();
        wr_en = 0;
        #1;
        chk("bypass_off_new", rd1[15:0], 32'h5555);

        wr_en = 1; wr_addr = 3'd0; wr_data = 16'hFFFF; rd_addr = {3'd2, 3'd0};
        #1;
        chk("z0_no_bypass", rd2[15:0], 32'h0);
        chk("r0_bypass_normal", rd0[15:0], 32'hFFFF);
        tick();
        wr_en = 0;
        #1;
        chk("z0_stored", rd2[15:0], 32'h0);
        chk("r0_stored_normal", rd0[15:0], 32'hFFFF);
        chk("z0_err", {31'b0, err2}, 32'h0);
        chk("z0_r2", rd2[31:16], 32'h5555);

        wr_en = 1; wr_addr = 3'd6; wr_data = 16'h7777; rd_addr = {3'd5, 3'd6};
        #1;
        chk("oor_no_bypass", rd3[15:0], 32'h0);
        chk("oor_err_before", {31'b0, err3}, 32'h0);
        chk("in_range_bypass_d0", rd0[15:0], 32'h7777);
        tick();
        wr_en = 0;
        #1;
        chk("oor_err_set", {31'b0, err3}, 32'h1);
        chk("d0_err_clear", {31'b0, err0}, 32'h0);
        chk("oor_read_zero", rd3, 32'h1234_0000);
        rd_addr = {3'd0, 3'd2};
        tick();
        chk("oor_err_pulse", {31'b0, err3}, 32'h0);
        chk("oor_others_kept", rd3, 32'hFFFF_5555);

        rst = 1; wr_en = 1; wr_addr = 3'd1; wr_data = 16'hCAFE; rd_addr = {3'd5, 3'd1};
        #1;
        chk("rst_no_bypass", rd0, 32'h1234_0000);
        tick();
        rst = 0; wr_en = 0;
        #1;
        chk("rst_write_dropped", rd0, 32'h0);
        chk("rst_err", {31'b0, err0}, 32'h0);

        wr(3'd4, 16'hA5A5);
        wr_addr = 'x; wr_data = 'x; rd_addr = {3'd4, 3'd1};
        #1;
        chk("x_safe_rd", rd0, 32'hA5A5_0000);
        tick();
        chk("x_safe_err", {31'b0, err0}, 32'h0);
        chk("x_safe_hold", rd0, 32'hA5A5_0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/param_regfile.md
Name: param_regfile

Overview:
- Parametrised multi-port register file: generalises the single fixed-width enabled register to NUM_REGS entries of WIDTH bits.
- NUM_RD independent read ports and one write port.
- Optional write-to-read bypass and optional hardwired-zero R0.
- Sits in the decode stage of the pipelined processor. It replaces per-register instances as the architectural register file.

Parameters:
- WIDTH, 16, data bits per register.
- NUM_REGS, 8, number of implemented registers (2..2**ADDR_W).
- ADDR_W, 3, address width of every read/write port.
- NUM_RD, 2, number of read ports (1..4).
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports; 0 = reads return stored value only.
- ZERO_R0, 0, 1 = register 0 always reads 0 and ignores writes.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- wr_en  input  1  write enable.
- wr_addr  input  ADDR_W  write address.
- wr_data  input  WIDTH  write data.
- rd_addr  input  NUM_RD*ADDR_W  packed read addresses; port i uses bits [i*ADDR_W +: ADDR_W].
- rd_data  output  NUM_RD*WIDTH  packed read data; port i uses bits [i*WIDTH +: WIDTH].
- err  output  1  registered: high for one cycle after a rising edge where wr_en was high with wr_addr >= NUM_REGS.

Behaviour:
- Storage: NUM_REGS x WIDTH, built from the team's dff cell with hold muxing. No latches, no other flop primitives.
- Reset: rst high at a rising edge clears every register to 0 and err to 0.
  - While rst is high, wr_en is ignored for both storage and bypass.
  - rd_data reflects stored contents: pre-reset values in the reset cycle, 0 afterwards.
- Write: on a rising edge with rst=0, wr_en=1, wr_addr < NUM_REGS (and wr_addr != 0 when ZERO_R0=1), register[wr_addr] <= wr_data.
  - All other registers hold.
  - Write latency 1 cycle to storage.
- Out-of-range write (wr_addr >= NUM_REGS):
  - No register changes.
  - err = 1 in the following cycle, 0 otherwise.
  - err is not sticky.
- Read: combinational, zero latency from rd_addr and stored state. Each port is independent; multiple ports may read the same address.
- Read of an out-of-range address returns 0.
- ZERO_R0=1: a read of address 0 returns 0 regardless of stored state or bypass. A write to address 0 is silently dropped (no err).
- Bypass (BYPASS=1): if rst=0, wr_en=1 and rd_addr[i]==wr_addr with wr_addr a writable address, rd_data[i] = wr_data in the same cycle. The ZERO_R0 and out-of-range rules take precedence.
- BYPASS=0: rd_data[i] shows the old value until after the edge.
- Width rules: no sign extension, no truncation. Full-width compare on addresses.
- X-safety: with wr_en=0, wr_addr/wr_data values must not affect outputs.

Test Plan:
- Reset: write 0xBEEF to R3, then assert rst for 1 cycle -> all read ports return 0x0000 after the reset edge; err=0.
- Write/read with defaults: write 0x1234 to R5; next cycle rd_addr0=5, rd_addr1=5 -> both ports read 0x1234. Other registers remain 0.
- Bypass: R2 holds 0x00AA; same cycle wr_en=1, wr_addr=2, wr_data=0x5555, rd_addr0=2.
  - BYPASS=1 -> rd_data0=0x5555 before the edge.
  - BYPASS=0 -> rd_data0=0x00AA before the edge, 0x5555 after.
- ZERO_R0=1: write 0xFFFF to R0 -> reads of R0 stay 0x0000 with or without bypass; err stays 0.
- Out of range (NUM_REGS=6, ADDR_W=3): write 0x7777 to addr 6 -> err=1 for exactly one cycle; reads of addr 6 return 0; R0–R5 unchanged.
- Write during reset: rst=1, wr_en=1, wr_addr=1, wr_data=0xCAFE -> after the edge R1 reads 0x0000; no bypass of 0xCAFE during that cycle.
